// File: rtl/arb_mux.sv
// N-input arbitrated mux with valid/ready handshakes and a single registered output stage.
// Fixed-priority (MODE 0) or round-robin (MODE 1) selection; one word per clock at full rate.
module arb_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned MODE  = 0,
    localparam int unsigned SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [SELW-1:0]   ptr_q, ptr_d;

    logic [N-1:0]      grant;
    logic [SELW-1:0]   grant_idx;
    logic [WIDTH-1:0]  grant_data;
    logic              found;
    logic              accept;
    logic              load;

    // Round-robin: first search indices at or above ptr, then wrap to the low indices.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && in_valid[i] && (MODE == 0 || i >= 32'(ptr_q))) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = SELW'(i);
            end
        end
        if (MODE == 1) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && in_valid[i]) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept   = (state_q == StEmpty) | out_ready;
    assign load     = accept & found;
    assign in_ready = rst_n ? (grant & {N{accept}}) : '0;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (load) begin
            state_d = StFull;
            data_d  = grant_data;
            sel_d   = grant_idx;
            if (MODE == 1) begin
                ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
            end
        end else if (state_q == StFull && out_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: one fixed-priority and one round-robin instance, each checked against
// a cycle-level reference model driven by directed and random source traffic.
module tb_arb_mux;

    localparam int unsigned W = 32;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N*W-1:0] in_data   [2];
    logic [N-1:0]   in_valid  [2];
    logic [N-1:0]   in_ready  [2];
    logic [W-1:0]   out_data  [2];
    logic [1:0]     out_sel   [2];
    logic           out_valid [2];
    logic           out_ready [2];

    // Source/sink stimulus per instance (index 0 = MODE 0, index 1 = MODE 1)
    logic           sv    [2][N];
    logic [W-1:0]   sdata [2][N];
    logic           sordy [2];

    // Reference model state
    logic           m_valid [2];
    logic [W-1:0]   m_data  [2];
    int             m_sel   [2];
    int             m_ptr   [2];
    int             g_save  [2];
    logic           acc_save [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arb_mux #(.WIDTH(W), .N(N), .MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_sel(out_sel[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0])
    );

    arb_mux #(.WIDTH(W), .N(N), .MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_sel(out_sel[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instance d uses round-robin when d == 1; order visited is ptr, ptr+1, ... mod N.
    function automatic int model_grant(int d);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (d == 1) ? (m_ptr[d] + k) % N : k;
            if (sv[d][idx]) return idx;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                in_valid[d][i]        = sv[d][i];
                in_data[d][i*W +: W]  = sdata[d][i];
            end
            out_ready[d] = sordy[d];
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_sel[d]   = 0;
            m_ptr[d]   = 0;
        end
    endtask

    task automatic set_all(input logic v, input logic rdy);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                sv[d][i]    = v;
                sdata[d][i] = 32'hA000_0000 + 32'(d * 16 + i);
            end
            sordy[d] = rdy;
        end
    endtask

    task automatic check_out(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_valid"}, 64'(out_valid[d]), 64'(m_valid[d]));
            check({tag, "_data"}, 64'(out_data[d]), 64'(m_data[d]));
            check({tag, "_sel"}, 64'(out_sel[d]), 64'(m_sel[d]));
        end
    endtask

    // One clock: drive, check in_ready before the edge, advance model, check outputs after.
    task automatic cycle(input string tag);
        drive();
        #1;
        for (int d = 0; d < 2; d++) begin
            logic [N-1:0] exp_rdy;
            g_save[d]   = model_grant(d);
            acc_save[d] = !m_valid[d] || sordy[d];
            exp_rdy     = '0;
            if (g_save[d] >= 0 && acc_save[d]) exp_rdy[g_save[d]] = 1'b1;
            check({tag, "_in_ready"}, 64'(in_ready[d]), 64'(exp_rdy));
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (g_save[d] >= 0 && acc_save[d]) begin
                m_valid[d] = 1'b1;
                m_data[d]  = sdata[d][g_save[d]];
                m_sel[d]   = g_save[d];
                if (d == 1) m_ptr[d] = (g_save[d] + 1) % N;
                sv[d][g_save[d]] = 1'b0;
            end else if (m_valid[d] && sordy[d]) begin
                m_valid[d] = 1'b0;
            end
        end
        check_out(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_all(1'b1, 1'b1);
        drive();
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            check("rst_in_ready", 64'(in_ready[d]), 64'(0));
        end
        check_out("rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_all(1'b0, 1'b1);
    endtask

    initial begin
        do_reset();

        // Single source on channel 2
        sv[0][2] = 1'b1; sdata[0][2] = 32'hDEADBEEF;
        sv[1][2] = 1'b1; sdata[1][2] = 32'hDEADBEEF;
        cycle("single");
        for (int d = 0; d < 2; d++) begin
            check("single_sel_const", 64'(out_sel[d]), 64'(2));
            check("single_data_const", 64'(out_data[d]), 64'(32'hDEADBEEF));
        end
        set_all(1'b0, 1'b1);
        cycle("drain");

        // All valid, sink always ready
        do_reset();
        for (int c = 0; c < 5; c++) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < N; i++) sv[d][i] = 1'b1;
            cycle("allv");
            check("allv_sel0_const", 64'(out_sel[0]), 64'(0));
            check("allv_sel1_const", 64'(out_sel[1]), 64'(c % N));
        end

        // Backpressure for 3 cycles, then release with no bubble
        for (int c = 0; c < 3; c++) begin
            sordy[0] = 1'b0; sordy[1] = 1'b0;
            cycle("stall");
        end
        sordy[0] = 1'b1; sordy[1] = 1'b1;
        cycle("release");
        check("release_valid_const", 64'(out_valid[0] & out_valid[1]), 64'(1));

        // Round-robin wrap/skip: set ptr to 1, then offer channels 0 and 3
        do_reset();
        sv[0][0] = 1'b1; sv[1][0] = 1'b1;
        cycle("rr_prep");
        for (int d = 0; d < 2; d++) begin
            sv[d][0] = 1'b1; sv[d][3] = 1'b1;
        end
        cycle("rr_a");
        check("rr_a_sel_const", 64'(out_sel[1]), 64'(3));
        cycle("rr_b");
        check("rr_b_sel_const", 64'(out_sel[1]), 64'(0));

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < N; i++) begin
                    if (!sv[d][i] && $urandom_range(0, 2) != 0) begin
                        sv[d][i]    = 1'b1;
                        sdata[d][i] = $urandom;
                    end
                end
                sordy[d] = ($urandom_range(0, 3) != 0);
            end
            cycle("rand");
        end

        // Reset while FULL and stalled
        set_all(1'b1, 1'b1);
        cycle("mid_fill");
        sordy[0] = 1'b0; sordy[1] = 1'b0;
        cycle("mid_hold");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            check("midrst_valid", 64'(out_valid[d]), 64'(0));
            check("midrst_in_ready", 64'(in_ready[d]), 64'(0));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_all(1'b1, 1'b1);
        cycle("after_rst");
        for (int d = 0; d < 2; d++) begin
            check("after_rst_sel_const", 64'(out_sel[d]), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
